// File: rtl/spi_flash_pkg.sv
// Shared SPI flash definitions: command opcodes, page geometry, sequencer
// state encoding and the page-chunk helper. The read path uses it as well.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN        = 8'h06;
    localparam logic [7:0] OP_PAGE_PROG   = 8'h12;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;

    localparam logic [8:0] PAGE_SIZE = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP,
        ST_PROG_HDR,
        ST_PROG_DATA,
        ST_POLL,
        ST_DONE
    } flash_state_t;

    // Sub-phase of a command-issuing state: start a byte, wait for it,
    // or hold cs_n low after the last falling spi_clk edge.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT,
        PH_TAIL
    } cmd_phase_t;

    // Bytes that fit in one program command without crossing a page.
    function automatic logic [8:0] chunk_len(input logic [31:0] remain,
                                             input logic [31:0] addr);
        logic [8:0] room;
        room = PAGE_SIZE - {1'b0, addr[7:0]};
        if (remain < {23'b0, room}) begin
            return remain[8:0];
        end
        return room;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode 0 byte engine: divides system_clk down to spi_clk and shifts one
// byte out on mosi (MSB first) while shifting one byte in from miso.
// A start is accepted only while idle; done pulses at the last falling edge.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       system_clk,
    input  logic       system_reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       spi_clk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic       active_reg;
    logic       sclk_reg;
    logic       mosi_reg;
    logic       done_reg;
    logic [6:0] tx_reg;
    logic [7:0] rx_reg;
    logic [7:0] div_cnt_reg;
    logic [2:0] bit_cnt_reg;

    // Half-period timer, edge generation and TX/RX shift registers.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            active_reg  <= 1'b0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            done_reg    <= 1'b0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (!active_reg) begin
                if (start) begin
                    // First bit goes out while spi_clk is still low.
                    active_reg  <= 1'b1;
                    tx_reg      <= tx_byte[6:0];
                    mosi_reg    <= tx_byte[7];
                    div_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                    sclk_reg    <= 1'b0;
                end
            end else if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                sclk_reg    <= ~sclk_reg;
                if (!sclk_reg) begin
                    // Rising edge: sample the slave.
                    rx_reg <= {rx_reg[6:0], miso};
                end else if (bit_cnt_reg == 3'd7) begin
                    // Last falling edge: byte complete, mosi keeps its value.
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                end else begin
                    // Falling edge: present the next bit.
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    mosi_reg    <= tx_reg[6];
                    tx_reg      <= {tx_reg[5:0], 1'b0};
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end
        end
    end

    assign spi_clk = sclk_reg;
    assign mosi    = mosi_reg;
    assign done    = done_reg;
    assign rx_byte = rx_reg;

endmodule

// File: rtl/spi_flash_page_write.sv
// SPI NOR page-program sequencer: for each page-bounded chunk it issues
// WREN, PAGE PROGRAM (opcode + 32-bit address + data from the write FIFO)
// and polls the status register until WIP clears.
module spi_flash_page_write
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        system_clk,
    input  logic        system_reset_n,
    input  logic        start_flag,
    input  logic [31:0] start_addr,
    input  logic [31:0] byte_count,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        cs_n,
    output logic        spi_clk,
    output logic        mosi,
    input  logic        miso,
    output logic        busy,
    output logic        write_finish,
    output logic [31:0] bytes_written
);

    localparam logic [15:0] GAP_LAST  = (CS_GAP < 1) ? 16'd0 : 16'(CS_GAP - 1);
    localparam logic [15:0] TAIL_LAST = 16'(CLK_DIV - 1);

    flash_state_t state_reg, state_next;
    flash_state_t after_gap_reg, after_gap_next;
    cmd_phase_t   phase_reg, phase_next;
    logic [31:0]  addr_reg, addr_next;
    logic [31:0]  remain_reg, remain_next;
    logic [31:0]  bytes_written_reg, bytes_written_next;
    logic [8:0]   byte_idx_reg, byte_idx_next;
    logic [15:0]  cnt_reg, cnt_next;
    logic         cs_n_reg, cs_n_next;
    logic         busy_reg, busy_next;

    logic         shift_start;
    logic [7:0]   shift_data;
    logic         shift_done;
    logic         shift_mosi;
    logic [7:0]   shift_rx;
    logic         unused_rx;
    logic [8:0]   chunk;
    logic [7:0]   hdr_byte [0:7];

    assign chunk     = chunk_len(remain_reg, addr_reg);
    assign unused_rx = ^shift_rx[7:1];

    // Program header bytes: opcode followed by the address, MSB first.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hdr
            if (gi == 0) begin : g_op
                assign hdr_byte[gi] = OP_PAGE_PROG;
            end else if (gi <= 4) begin : g_addr
                assign hdr_byte[gi] = addr_reg[39 - 8 * gi -: 8];
            end else begin : g_pad
                assign hdr_byte[gi] = 8'h00;
            end
        end
    endgenerate

    spi_byte_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .system_clk    (system_clk),
        .system_reset_n(system_reset_n),
        .start         (shift_start),
        .tx_byte       (shift_data),
        .miso          (miso),
        .spi_clk       (spi_clk),
        .mosi          (shift_mosi),
        .done          (shift_done),
        .rx_byte       (shift_rx)
    );

    // Sequencer state, address/length bookkeeping and chip select.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_reg         <= ST_IDLE;
            after_gap_reg     <= ST_IDLE;
            phase_reg         <= PH_ISSUE;
            addr_reg          <= '0;
            remain_reg        <= '0;
            bytes_written_reg <= '0;
            byte_idx_reg      <= '0;
            cnt_reg           <= '0;
            cs_n_reg          <= 1'b1;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            after_gap_reg     <= after_gap_next;
            phase_reg         <= phase_next;
            addr_reg          <= addr_next;
            remain_reg        <= remain_next;
            bytes_written_reg <= bytes_written_next;
            byte_idx_reg      <= byte_idx_next;
            cnt_reg           <= cnt_next;
            cs_n_reg          <= cs_n_next;
            busy_reg          <= busy_next;
        end
    end

    // Next-state logic, byte requests to the shifter and FIFO pops.
    always_comb begin
        state_next         = state_reg;
        after_gap_next     = after_gap_reg;
        phase_next         = phase_reg;
        addr_next          = addr_reg;
        remain_next        = remain_reg;
        bytes_written_next = bytes_written_reg;
        byte_idx_next      = byte_idx_reg;
        cnt_next           = cnt_reg;
        cs_n_next          = cs_n_reg;
        busy_next          = busy_reg;
        shift_start        = 1'b0;
        shift_data         = 8'h00;
        wr_ready           = 1'b0;

        if (phase_reg == PH_TAIL) begin
            // Hold cs_n low after the final falling edge, then release it.
            if (cnt_reg == TAIL_LAST) begin
                cs_n_next  = 1'b1;
                state_next = ST_GAP;
                phase_next = PH_ISSUE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 16'd1;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_flag) begin
                        addr_next          = start_addr;
                        remain_next        = byte_count;
                        bytes_written_next = '0;
                        phase_next         = PH_ISSUE;
                        byte_idx_next      = '0;
                        if (byte_count == 32'd0) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_WREN;
                            busy_next  = 1'b1;
                        end
                    end
                end
                ST_WREN: begin
                    if (phase_reg == PH_ISSUE) begin
                        cs_n_next   = 1'b0;
                        shift_start = 1'b1;
                        shift_data  = OP_WREN;
                        phase_next  = PH_WAIT;
                    end else if (shift_done) begin
                        phase_next     = PH_TAIL;
                        cnt_next       = '0;
                        after_gap_next = ST_PROG_HDR;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_next    = after_gap_reg;
                        phase_next    = PH_ISSUE;
                        byte_idx_next = '0;
                        cnt_next      = '0;
                        if (after_gap_reg == ST_DONE) begin
                            busy_next = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                ST_PROG_HDR: begin
                    if (phase_reg == PH_ISSUE) begin
                        cs_n_next   = 1'b0;
                        shift_start = 1'b1;
                        shift_data  = hdr_byte[byte_idx_reg[2:0]];
                        phase_next  = PH_WAIT;
                    end else if (shift_done) begin
                        phase_next = PH_ISSUE;
                        if (byte_idx_reg == 9'd4) begin
                            state_next    = ST_PROG_DATA;
                            byte_idx_next = '0;
                        end else begin
                            byte_idx_next = byte_idx_reg + 9'd1;
                        end
                    end
                end
                ST_PROG_DATA: begin
                    if (phase_reg == PH_ISSUE) begin
                        // An empty FIFO simply parks here with spi_clk low.
                        if (wr_valid) begin
                            wr_ready    = 1'b1;
                            shift_start = 1'b1;
                            shift_data  = wr_data;
                            phase_next  = PH_WAIT;
                        end
                    end else if (shift_done) begin
                        if (byte_idx_reg + 9'd1 == chunk) begin
                            addr_next          = addr_reg + {23'b0, chunk};
                            remain_next        = remain_reg - {23'b0, chunk};
                            bytes_written_next = bytes_written_reg + {23'b0, chunk};
                            byte_idx_next      = '0;
                            phase_next         = PH_TAIL;
                            cnt_next           = '0;
                            after_gap_next     = ST_POLL;
                        end else begin
                            byte_idx_next = byte_idx_reg + 9'd1;
                            phase_next    = PH_ISSUE;
                        end
                    end
                end
                ST_POLL: begin
                    if (phase_reg == PH_ISSUE) begin
                        cs_n_next   = 1'b0;
                        shift_start = 1'b1;
                        shift_data  = (byte_idx_reg == 9'd0) ? OP_READ_STATUS : 8'h00;
                        phase_next  = PH_WAIT;
                    end else if (shift_done) begin
                        if ((byte_idx_reg != 9'd0) && !shift_rx[0]) begin
                            phase_next     = PH_TAIL;
                            cnt_next       = '0;
                            byte_idx_next  = '0;
                            after_gap_next = (remain_reg != 32'd0) ? ST_WREN : ST_DONE;
                        end else begin
                            byte_idx_next = 9'd1;
                            phase_next    = PH_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign cs_n          = cs_n_reg;
    assign mosi          = ~cs_n_reg & shift_mosi;
    assign busy          = busy_reg;
    assign write_finish  = (state_reg == ST_DONE);
    assign bytes_written = bytes_written_reg;

endmodule

// File: tb/tb_spi_flash_page_write.sv
// Testbench for spi_flash_page_write: table of write jobs plus random jobs,
// a behavioural SPI flash, a show-ahead FIFO and a command-stream model.
module tb_spi_flash_page_write;

    logic        system_clk = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        start_flag = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] byte_count = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        cs_n;
    logic        spi_clk;
    logic        mosi;
    logic        miso = 1'b0;
    logic        busy;
    logic        write_finish;
    logic [31:0] bytes_written;

    spi_flash_page_write #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .system_clk    (system_clk),
        .system_reset_n(system_reset_n),
        .start_flag    (start_flag),
        .start_addr    (start_addr),
        .byte_count    (byte_count),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .cs_n          (cs_n),
        .spi_clk       (spi_clk),
        .mosi          (mosi),
        .miso          (miso),
        .busy          (busy),
        .write_finish  (write_finish),
        .bytes_written (bytes_written)
    );

    initial forever #5 system_clk = ~system_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- write FIFO (show-ahead) ----------------
    logic [7:0] fifo_q[$];
    int pops = 0, underflow = 0;
    int stall_after = 0, stall_rem = 0, stall_samples = 0, stall_viol = 0;
    logic stall_mosi = 1'b0;

    initial forever begin
        @(posedge system_clk);
        if (wr_ready === 1'b1) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            else underflow++;
            pops++;
        end
    end

    initial forever begin
        @(negedge system_clk);
        if (stall_rem > 0 && pops == stall_after) begin
            wr_valid = 1'b0;
            if (stall_rem <= 10) begin
                if (stall_rem == 10) stall_mosi = mosi;
                stall_samples++;
                if (spi_clk !== 1'b0 || cs_n !== 1'b0 || wr_ready !== 1'b0 || mosi !== stall_mosi)
                    stall_viol++;
            end
            stall_rem--;
        end else begin
            wr_valid = (fifo_q.size() > 0);
            wr_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    // ---------------- behavioural SPI flash ----------------
    logic [7:0] obs_bytes[$];
    int obs_lens[$];
    int wip_n = 0, cs_falls = 0, stray_clk = 0, finish_cnt = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;
    int cur_bits = 0, cur_len = 0;
    logic [7:0] cur_byte = '0, cur_op = '0;

    initial forever begin
        @(cs_n or spi_clk);
        if (cs_n !== prev_cs) begin
            if (cs_n === 1'b0) begin
                cur_bits = 0; cur_len = 0; cur_byte = '0; cur_op = '0; miso = 1'b0;
                cs_falls++;
            end else if (cs_n === 1'b1) begin
                if (cur_bits > 0) obs_lens.push_back(cur_len);
                miso = 1'b0;
            end
            prev_cs = cs_n;
        end
        if (spi_clk !== prev_sclk) begin
            if (spi_clk === 1'b1) begin
                if (cs_n === 1'b0) begin
                    cur_byte = {cur_byte[6:0], mosi};
                    cur_bits++;
                    if (cur_bits % 8 == 0) begin
                        obs_bytes.push_back(cur_byte);
                        if (cur_len == 0) cur_op = cur_byte;
                        cur_len++;
                    end
                end else begin
                    stray_clk++;
                end
            end else if (spi_clk === 1'b0 && cs_n === 1'b0 && cur_len > 0 && cur_op == 8'h05) begin
                int k;
                logic [7:0] st;
                k  = cur_bits - 8;
                st = ((k / 8) < wip_n) ? 8'h01 : 8'h00;
                miso = st[7 - (k % 8)];
            end
            prev_sclk = spi_clk;
        end
    end

    initial forever begin
        @(posedge system_clk);
        if (write_finish === 1'b1) finish_cnt++;
    end

    // ---------------- command-stream reference model ----------------
    logic [7:0] model_data[$];
    logic [7:0] exp_bytes[$];
    int exp_lens[$];

    task automatic build_model(input logic [31:0] addr, input int count, input int wip);
        logic [31:0] a;
        int r, c, room, di;
        exp_bytes.delete();
        exp_lens.delete();
        a = addr; r = count; di = 0;
        while (r > 0) begin
            room = 256 - int'(a % 256);
            c = (r < room) ? r : room;
            exp_bytes.push_back(8'h06);
            exp_lens.push_back(1);
            exp_bytes.push_back(8'h12);
            for (int s = 3; s >= 0; s--) exp_bytes.push_back(8'(a >> (8 * s)));
            for (int j = 0; j < c; j++) begin
                exp_bytes.push_back(model_data[di]);
                di++;
            end
            exp_lens.push_back(5 + c);
            exp_bytes.push_back(8'h05);
            for (int j = 0; j <= wip; j++) exp_bytes.push_back(8'h00);
            exp_lens.push_back(wip + 2);
            a = a + 32'(c);
            r = r - c;
        end
    endtask

    task automatic compare_logs(input string tag);
        int n, len_mism, byte_mism;
        check({tag, " cmd_count"}, obs_lens.size(), exp_lens.size());
        n = (obs_lens.size() < exp_lens.size()) ? obs_lens.size() : exp_lens.size();
        len_mism = 0;
        for (int i = 0; i < n; i++) if (obs_lens[i] != exp_lens[i]) len_mism++;
        check({tag, " cmd_len_mismatches"}, len_mism, 0);
        check({tag, " byte_total"}, obs_bytes.size(), exp_bytes.size());
        n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
        byte_mism = 0;
        for (int i = 0; i < n; i++) if (obs_bytes[i] !== exp_bytes[i]) byte_mism++;
        check({tag, " byte_mismatches"}, byte_mism, 0);
    endtask

    // ---------------- job table ----------------
    typedef struct {
        logic [31:0] addr;
        int          count;
        int          wip;
        int          stall_after;
        int          stall_len;
        bit          restart;
        int          exp_cmds;   // -1: only the model decides
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    logic [7:0] fixed_data [4];

    task automatic clear_logs();
        obs_bytes.delete();
        obs_lens.delete();
        cs_falls = 0; stray_clk = 0; finish_cnt = 0; underflow = 0;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int cyc;
        logic [7:0] d;
        string tag;
        tag = $sformatf("vec%0d", vi);
        fifo_q.delete();
        model_data.delete();
        for (int k = 0; k < v.count; k++) begin
            d = (vi == 0) ? fixed_data[k] : 8'($urandom);
            fifo_q.push_back(d);
            model_data.push_back(d);
        end
        wip_n = v.wip;
        pops = 0;
        stall_after = v.stall_after;
        stall_samples = 0;
        stall_viol = 0;
        stall_rem = v.stall_len;
        clear_logs();
        build_model(v.addr, v.count, v.wip);

        @(negedge system_clk);
        start_addr = v.addr;
        byte_count = 32'(v.count);
        start_flag = 1'b1;
        @(negedge system_clk);
        start_flag = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        if (v.restart) begin
            repeat (60) @(negedge system_clk);
            start_addr = 32'h0000_5555;
            byte_count = 32'd9;
            start_flag = 1'b1;
            @(negedge system_clk);
            start_flag = 1'b0;
        end
        cyc = 0;
        while (finish_cnt == 0 && cyc < 15000) begin
            @(negedge system_clk);
            cyc++;
        end
        check({tag, " finish_seen"}, (finish_cnt != 0), 1);
        repeat (20) @(negedge system_clk);
        check({tag, " finish_once"}, finish_cnt, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " bytes_written"}, bytes_written, 32'(v.count));
        check({tag, " fifo_drained"}, fifo_q.size(), 0);
        check({tag, " fifo_underflow"}, underflow, 0);
        check({tag, " stray_clk"}, stray_clk, 0);
        check({tag, " cs_falls"}, cs_falls, exp_lens.size());
        if (v.exp_cmds >= 0) check({tag, " table_cmds"}, obs_lens.size(), v.exp_cmds);
        compare_logs(tag);
        if (v.stall_len > 0) begin
            check({tag, " stall_samples"}, stall_samples, 10);
            check({tag, " stall_static"}, stall_viol, 0);
        end
        $display("job %0d addr=%08h count=%0d wip=%0d cmds=%0d bytes_written=%0d",
                 vi, v.addr, v.count, v.wip, obs_lens.size(), bytes_written);
    endtask

    initial begin
        int cyc;
        fixed_data[0] = 8'hA5; fixed_data[1] = 8'h5A;
        fixed_data[2] = 8'h01; fixed_data[3] = 8'hFF;
        //             addr           cnt  wip stA stL rst exp
        vecs[0] = '{32'h0000_0000,    4,  0,  0,  0, 0,  3};
        vecs[1] = '{32'h0000_00FE,    4,  0,  0,  0, 0,  6};
        vecs[2] = '{32'h0000_1000,    3,  3,  0,  0, 0,  3};
        vecs[3] = '{32'h0000_0020,    5,  0,  2, 50, 0,  3};
        vecs[4] = '{32'h0000_0300,    6,  1,  0,  0, 1,  3};
        vecs[5] = '{32'h0000_01FF,  258,  0,  0,  0, 0,  9};
        for (int i = 6; i < NVEC; i++) begin
            vecs[i].addr        = ($urandom & 32'hFFFF_FF00) | 32'(8'hF0 + $urandom_range(0, 15));
            vecs[i].count       = $urandom_range(1, 40);
            vecs[i].wip         = $urandom_range(0, 2);
            vecs[i].stall_after = 0;
            vecs[i].stall_len   = 0;
            vecs[i].restart     = 1'b0;
            vecs[i].exp_cmds    = -1;
        end

        // Reset state.
        system_reset_n = 1'b0;
        repeat (3) @(negedge system_clk);
        system_reset_n = 1'b1;
        @(negedge system_clk);
        check("reset cs_n", cs_n, 1);
        check("reset spi_clk", spi_clk, 0);
        check("reset mosi", mosi, 0);
        check("reset busy", busy, 0);
        check("reset write_finish", write_finish, 0);
        check("reset wr_ready", wr_ready, 0);
        check("reset bytes_written", bytes_written, 0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Zero-length job: finish pulse one cycle after start, no SPI traffic.
        clear_logs();
        @(negedge system_clk);
        start_addr = 32'h0000_1234;
        byte_count = 32'd0;
        start_flag = 1'b1;
        @(negedge system_clk);
        start_flag = 1'b0;
        check("zero finish_cycle1", write_finish, 1);
        check("zero busy_cycle1", busy, 0);
        @(negedge system_clk);
        check("zero finish_cycle2", write_finish, 0);
        repeat (20) @(negedge system_clk);
        check("zero cs_falls", cs_falls, 0);
        check("zero finish_once", finish_cnt, 1);
        check("zero bytes_written", bytes_written, 0);
        $display("job zero-length finish_pulses=%0d cs_falls=%0d", finish_cnt, cs_falls);

        // Asynchronous reset while the first data byte is being shifted.
        fifo_q.delete();
        for (int k = 0; k < 8; k++) fifo_q.push_back(8'($urandom));
        pops = 0;
        stall_rem = 0;
        wip_n = 0;
        clear_logs();
        @(negedge system_clk);
        start_addr = 32'h0000_0040;
        byte_count = 32'd8;
        start_flag = 1'b1;
        @(negedge system_clk);
        start_flag = 1'b0;
        cyc = 0;
        while (pops < 1 && cyc < 3000) begin
            @(negedge system_clk);
            cyc++;
        end
        check("abort reached_data", (pops >= 1), 1);
        repeat (10) @(negedge system_clk);
        #2 system_reset_n = 1'b0;
        #1;
        check("abort cs_n", cs_n, 1);
        check("abort spi_clk", spi_clk, 0);
        check("abort busy", busy, 0);
        check("abort wr_ready", wr_ready, 0);
        repeat (3) @(negedge system_clk);
        system_reset_n = 1'b1;
        fifo_q.delete();
        repeat (300) @(negedge system_clk);
        check("abort no_finish", finish_cnt, 0);
        check("abort busy_after", busy, 0);
        check("abort bytes_written", bytes_written, 0);
        $display("job reset-abort finish_pulses=%0d busy=%0d", finish_cnt, busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
